// File: rtl/jcb_pkg.sv
// jcb_pkg: opcode constants, FSM state encoding and default interrupt vector for jump_ctrl_stack
package jcb_pkg;

    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_JV  = 6'b011100;
    localparam logic [5:0] OP_JNV = 6'b011101;
    localparam logic [5:0] OP_JZ  = 6'b011110;
    localparam logic [5:0] OP_JNZ = 6'b011111;

    localparam logic [15:0] DEF_VEC_ADDR = 16'hF000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VECTOR  = 2'd1,
        FLAGCAP = 2'd2
    } state_t;

endpackage

// File: rtl/jcb_ret_stack.sv
// jcb_ret_stack: saturating LIFO of {return address, flags} with in-place flag update of the top entry
module jcb_ret_stack #(
    parameter int ADDR_W = 16,
    parameter int FLAG_W = 2,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              wr_flag,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [FLAG_W-1:0] flag_in,
    output logic [ADDR_W-1:0] top_addr,
    output logic [FLAG_W-1:0] top_flag,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [FLAG_W-1:0] flag_mem [DEPTH];
    logic [CW-1:0]     cnt_m1;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;

    // top-of-stack view and occupancy flags; an empty stack reads as zero
    always_comb begin
        cnt_m1   = count - 1'b1;
        top_idx  = cnt_m1[IW-1:0];
        wr_idx   = count[IW-1:0];
        full     = count == CW'(DEPTH);
        empty    = count == '0;
        top_addr = empty ? '0 : addr_mem[top_idx];
        top_flag = empty ? '0 : flag_mem[top_idx];
    end

    // push/pop never move the pointer past full or empty; flags of a new entry start cleared
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                flag_mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                addr_mem[wr_idx] <= push_addr;
                flag_mem[wr_idx] <= '0;
                count            <= count + 1'b1;
            end else if (pop && !empty) begin
                count <= count - 1'b1;
            end
            if (wr_flag && !empty)
                flag_mem[top_idx] <= flag_in;
        end
    end

endmodule

// File: rtl/jump_ctrl_stack.sv
// jump_ctrl_stack: jump/branch target selection with nested interrupt entry and return stack
module jump_ctrl_stack
    import jcb_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                FLAG_W   = 2,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(DEF_VEC_ADDR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [5:0]                 op,
    input  logic [ADDR_W-1:0]          jmp_address_pm,
    input  logic [ADDR_W-1:0]          current_address,
    input  logic [FLAG_W-1:0]          flag_ex,
    input  logic                       interrupt,
    output logic [ADDR_W-1:0]          jmp_loc,
    output logic                       pc_mux_sel,
    output logic                       int_ack,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       ovf_err,
    output logic                       unf_err
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] jmp_r;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top_addr;
    logic [FLAG_W-1:0] top_flag;
    logic [FLAG_W-1:0] sel;
    logic              is_ret, taken, ret_ok, accept, pop, wr_flag, full, empty;

    jcb_ret_stack #(
        .ADDR_W (ADDR_W),
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .pop       (pop),
        .wr_flag   (wr_flag),
        .push_addr (ret_addr),
        .flag_in   (flag_ex),
        .top_addr  (top_addr),
        .top_flag  (top_flag),
        .full      (full),
        .empty     (empty),
        .count     (depth)
    );

    // decode, interrupt acceptance, next state and next-PC selection
    always_comb begin
        is_ret     = op == OP_RET;
        sel        = is_ret ? top_flag : flag_ex;
        taken      = (op == OP_JMP) | ((op == OP_JV) & sel[0]) | ((op == OP_JNV) & ~sel[0])
                   | ((op == OP_JZ) & sel[1]) | ((op == OP_JNZ) & ~sel[1]);
        ret_ok     = (state == IDLE) && is_ret && !empty;
        accept     = reset && (state == IDLE) && interrupt && !is_ret && !full;
        pop        = reset && ret_ok;
        wr_flag    = reset && (state == FLAGCAP);
        ret_addr   = current_address + ADDR_W'(1);
        int_ack    = accept;
        next_state = !reset ? IDLE
                   : state == VECTOR  ? FLAGCAP
                   : state == FLAGCAP ? IDLE
                   : accept ? VECTOR : IDLE;
        pc_mux_sel = (state == VECTOR) || ret_ok || taken;
        jmp_loc    = state == VECTOR ? VEC_ADDR : ret_ok ? top_addr : jmp_r;
    end

    // interrupt entry sequencer state
    always_ff @(posedge clk) begin
        state <= next_state;
    end

    // registered jump target and sticky stack error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            jmp_r   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            jmp_r   <= jmp_address_pm;
            ovf_err <= ovf_err | ((state == IDLE) && interrupt && full);
            unf_err <= unf_err | (is_ret && empty);
        end
    end

endmodule

// File: tb/tb_jump_ctrl_stack.sv
// tb_jump_ctrl_stack: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_jump_ctrl_stack;

    localparam logic [5:0] N   = 6'b000000;
    localparam logic [5:0] JMP = 6'b011000;
    localparam logic [5:0] RET = 6'b010000;
    localparam logic [5:0] JV  = 6'b011100;
    localparam logic [5:0] JNV = 6'b011101;
    localparam logic [5:0] JZ  = 6'b011110;
    localparam logic [5:0] JNZ = 6'b011111;

    typedef struct {
        string       nm;
        logic [15:0] jl;
        logic        sel;
        logic        ack;
        logic [2:0]  d;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [15:0] pm;
    logic [15:0] ca;
    logic [1:0]  fl;
    logic        intr;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic        int_ack;
    logic [2:0]  depth;
    logic        ovf_err;
    logic        unf_err;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    jump_ctrl_stack dut (
        .clk             (clk),
        .reset           (reset),
        .op              (op),
        .jmp_address_pm  (pm),
        .current_address (ca),
        .flag_ex         (fl),
        .interrupt       (intr),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .int_ack         (int_ack),
        .depth           (depth),
        .ovf_err         (ovf_err),
        .unf_err         (unf_err)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic [5:0] o, input logic [15:0] a,
                        input logic [1:0] f, input logic ir, input logic [15:0] ejl, input logic es,
                        input logic ea, input logic [2:0] ed, input logic eo, input logic eu);
        exp_t e;
        reset = r;
        op    = o;
        ca    = a;
        fl    = f;
        intr  = ir;
        e.nm  = nm;
        e.jl  = ejl;
        e.sel = es;
        e.ack = ea;
        e.d   = ed;
        e.ovf = eo;
        e.unf = eu;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            vectors++;
            if ({jmp_loc, pc_mux_sel, int_ack, depth, ovf_err, unf_err} !==
                {cur.jl, cur.sel, cur.ack, cur.d, cur.ovf, cur.unf}) begin
                miscompares++;
                $display("FAIL %s: got jl=%h sel=%b ack=%b d=%0d ovf=%b unf=%b, want jl=%h sel=%b ack=%b d=%0d ovf=%b unf=%b",
                         cur.nm, jmp_loc, pc_mux_sel, int_ack, depth, ovf_err, unf_err,
                         cur.jl, cur.sel, cur.ack, cur.d, cur.ovf, cur.unf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        op    = N;
        pm    = 16'h1234;
        ca    = 16'h0000;
        fl    = 2'b00;
        intr  = 1'b0;
        @(posedge clk);
        #1;
        step("reset",       0, N,   16'h0000, 2'b00, 1, 16'h0000, 0, 0, 0, 0, 0);
        step("jmp",         1, JMP, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 0, 0, 0);
        step("jv_taken",    1, JV,  16'h0000, 2'b01, 0, 16'h1234, 1, 0, 0, 0, 0);
        step("jnv_not",     1, JNV, 16'h0000, 2'b01, 0, 16'h1234, 0, 0, 0, 0, 0);
        step("jz_taken",    1, JZ,  16'h0000, 2'b10, 0, 16'h1234, 1, 0, 0, 0, 0);
        pm = 16'h5678;
        step("jnz_taken",   1, JNZ, 16'h0000, 2'b00, 0, 16'h1234, 1, 0, 0, 0, 0);
        pm = 16'h1234;
        step("jz_not",      1, JZ,  16'h0000, 2'b01, 0, 16'h5678, 0, 0, 0, 0, 0);
        step("jnv_taken",   1, JNV, 16'h0000, 2'b10, 0, 16'h1234, 1, 0, 0, 0, 0);
        step("int_ack",     1, N,   16'h0010, 2'b00, 1, 16'h1234, 0, 1, 0, 0, 0);
        step("vector",      1, JZ,  16'h0010, 2'b00, 0, 16'hF000, 1, 0, 1, 0, 0);
        step("flagcap",     1, N,   16'h0010, 2'b01, 0, 16'h1234, 0, 0, 1, 0, 0);
        step("ret",         1, RET, 16'h0020, 2'b10, 0, 16'h0011, 1, 0, 1, 0, 0);
        step("jv_live",     1, JV,  16'h0011, 2'b10, 0, 16'h1234, 0, 0, 0, 0, 0);
        step("ret_unf",     1, RET, 16'h0012, 2'b00, 0, 16'h1234, 0, 0, 0, 0, 0);
        step("unf_sticky",  1, N,   16'h0013, 2'b00, 0, 16'h1234, 0, 0, 0, 0, 1);
        step("rst_a",       0, N,   16'h0000, 2'b00, 0, 16'h1234, 0, 0, 0, 0, 1);
        step("post_rst",    1, N,   16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("nest_ack", 1, N, 16'h0100, 2'b00, 1, 16'h1234, 0, 1, 3'(i),     0, 0);
            step("nest_vec", 1, N, 16'h0100, 2'b00, 1, 16'hF000, 1, 0, 3'(i + 1), 0, 0);
            step("nest_cap", 1, N, 16'h0100, 2'b11, 1, 16'h1234, 0, 0, 3'(i + 1), 0, 0);
        end
        step("full_refuse", 1, N,   16'h0100, 2'b00, 1, 16'h1234, 0, 0, 4, 0, 0);
        step("ovf_set",     1, N,   16'h0100, 2'b00, 1, 16'h1234, 0, 0, 4, 1, 0);
        step("ret_defer",   1, RET, 16'h0200, 2'b00, 1, 16'h0101, 1, 0, 4, 1, 0);
        step("ack_after",   1, N,   16'h0100, 2'b00, 1, 16'h1234, 0, 1, 3, 1, 0);
        step("vec5",        1, N,   16'h0100, 2'b00, 0, 16'hF000, 1, 0, 4, 1, 0);
        step("cap_ret_ign", 1, RET, 16'h0100, 2'b00, 0, 16'h1234, 0, 0, 4, 1, 0);
        step("rst_b",       0, N,   16'h0000, 2'b00, 0, 16'h1234, 0, 0, 4, 1, 0);
        step("post_rst_b",  1, N,   16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 0, 0);
        step("ret_unf2",    1, RET, 16'h0000, 2'b00, 0, 16'h1234, 0, 0, 0, 0, 0);
        step("wrap_ack",    1, N,   16'hFFFF, 2'b00, 1, 16'h1234, 0, 1, 0, 0, 1);
        step("wrap_vec",    1, N,   16'hFFFF, 2'b00, 0, 16'hF000, 1, 0, 1, 0, 1);
        step("wrap_cap",    1, N,   16'hFFFF, 2'b10, 0, 16'h1234, 0, 0, 1, 0, 1);
        step("ret_int",     1, RET, 16'h0000, 2'b00, 1, 16'h0000, 1, 0, 1, 0, 1);
        step("ack_late",    1, N,   16'h0000, 2'b00, 1, 16'h1234, 0, 1, 0, 0, 1);
        step("rst_in_vec",  0, N,   16'h0000, 2'b00, 0, 16'hF000, 1, 0, 1, 0, 1);
        step("after_abort", 1, N,   16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 0, 0);
        step("idle_nop",    1, N,   16'h0000, 2'b00, 0, 16'h1234, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jump_ctrl_stack.md
JUMP_CTRL_STACK -- requirements
Module: jump_ctrl_stack

Interface
REQ-001 Parameter ADDR_W, default 16: program-address width.
REQ-002 Parameter FLAG_W, default 2: flag width; bit0 = overflow (V), bit1 = zero (Z).
REQ-003 Parameter DEPTH, default 4: maximum interrupt nesting depth (return-stack entries), DEPTH >= 1.
REQ-004 Parameter VEC_ADDR, default 'hF000 (ADDR_W bits): interrupt vector address.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 op  in  6  opcode of the instruction in decode.
REQ-008 jmp_address_pm  in  ADDR_W  jump target field from program memory.
REQ-009 current_address  in  ADDR_W  PC of the instruction in decode.
REQ-010 flag_ex  in  FLAG_W  flags from the execute stage.
REQ-011 interrupt  in  1  level interrupt request; held until int_ack.
REQ-012 jmp_loc  out  ADDR_W  next-PC target.
REQ-013 pc_mux_sel  out  1  1 = PC loads jmp_loc.
REQ-014 int_ack  out  1  one-cycle pulse on interrupt acceptance.
REQ-015 depth  out  $clog2(DEPTH+1)  current stack occupancy.
REQ-016 ovf_err, unf_err  out  1 each  sticky overflow and underflow errors.

Function
REQ-017 Decode SHALL be: JMP 011000, RET 010000, JV 011100, JNV 011101, JZ 011110, JNZ 011111; all other opcodes are non-jumps.
REQ-018 FSM states SHALL be IDLE, VECTOR and FLAGCAP; VECTOR -> FLAGCAP -> IDLE unconditionally, one cycle each.
REQ-019 Acceptance SHALL occur at an edge where state = IDLE, interrupt = 1, op != RET and depth < DEPTH; that edge pushes (current_address+1) mod 2^ADDR_W, enters VECTOR and int_ack is high in the preceding cycle.
REQ-020 In VECTOR, jmp_loc = VEC_ADDR and pc_mux_sel = 1, overriding any opcode.
REQ-021 In FLAGCAP, flag_ex SHALL be written into the flag field of the entry just pushed; RET is ignored in this cycle, and other jumps evaluate normally.
REQ-022 For non-RET jumps, jmp_loc SHALL be jmp_address_pm registered one cycle, updated every cycle outside reset.
REQ-023 Conditional selection SHALL be: JV taken if sel[0] = 1, JNV if sel[0] = 0, JZ if sel[1] = 1, JNZ if sel[1] = 0; JMP always taken. sel = flag_ex, except sel = top-of-stack flags while op = RET.
REQ-024 RET in IDLE with depth > 0: jmp_loc = top address (combinational), pc_mux_sel = 1, pop at the next edge.
REQ-025 RET with depth = 0: pc_mux_sel = 0, no pop, unf_err set at the next edge.
REQ-026 An interrupt request with depth = DEPTH in IDLE SHALL be refused and SHALL set ovf_err; the request remains pending.
REQ-027 Interrupt coincident with RET SHALL defer acceptance; the RET pops first, and acceptance occurs at the next eligible edge.
REQ-028 Stack pointer SHALL never wrap; push at full or pop at empty leaves it unchanged.
REQ-029 pc_mux_sel SHALL be combinational from op, sel, state and depth; there is no other output latency.

Reset
REQ-030 At any edge with reset = 0: state = IDLE, depth = 0, registered jump target = 0, stack entries = 0, ovf_err = unf_err = 0, int_ack = 0.
REQ-031 Reset asserted mid-sequence (VECTOR or FLAGCAP) SHALL abort the sequence with no flag write.
REQ-032 After reset, jmp_loc = 0, and pc_mux_sel = 0 unless op decodes a taken jump.

Structure
REQ-033 Package jcb_pkg SHALL hold the opcode constants, the FSM state enum and the default VEC_ADDR.
REQ-034 Sub-module jcb_ret_stack SHALL implement the LIFO {addr, flags} with push, pop, flag-write-at-top, full, empty and count.

Verification
REQ-035 interrupt=1 at PC 0x0010 -> int_ack pulse; next cycle jmp_loc = 0xF000, pc_mux_sel = 1; depth = 1; stored address 0x0011.
REQ-036 Then flag_ex = 2'b01 during FLAGCAP, later op = RET with flag_ex = 2'b10 -> jmp_loc = 0x0011, pc_mux_sel = 1, depth = 0; a following JV sees the live flag_ex.
REQ-037 Five nested interrupts with DEPTH = 4 -> depth saturates at 4, ovf_err = 1, and the fifth request gets no int_ack until a RET.
REQ-038 RET at depth 0 -> pc_mux_sel = 0, unf_err = 1, depth stays 0.
REQ-039 current_address = 0xFFFF when accepted -> stored return address 0x0000; interrupt plus RET in the same cycle -> pop first, ack one cycle later.
REQ-040 reset = 0 during VECTOR -> next cycle depth = 0, pc_mux_sel = 0 for op = 000000, errors clear.
